deg_conv_arbiter: RTL and testbench
===================================

Name: deg_conv_arbiter

Overview:
- Shares one binary-to-degree converter between N_REQ requesters using round-robin arbitration.
- The converter has a 22-bit binary input, a 14-bit degree output, and a start/finished handshake.
- For each accepted request the block latches the operand, starts the converter, waits for finished (or a timeout), then returns the degree result to the owning requester.
- Placement: between the angle-producing blocks and the single converter instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BIN_W, 22, operand width.
- DEG_W, 14, result width.
- TIMEOUT_CYC, 64, maximum cycles in WAIT before the conversion is aborted (must be ≥ 16).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_req  in  N_REQ  level request per requester.
- i_binary  in  N_REQ*BIN_W  operands; requester k uses bits [k*BIN_W +: BIN_W].
- o_ack  out  N_REQ  one-cycle pulse: request accepted, operand captured.
- o_done  out  N_REQ  one-cycle pulse: result valid on o_deg/o_err.
- o_deg  out  DEG_W  result; valid only while any o_done bit is high.
- o_err  out  1  high with o_done when the conversion timed out.
- o_busy  out  1  high in every state except IDLE.
- o_conv_start  out  1  converter start pulse.
- o_conv_binary  out  BIN_W  converter operand.
- i_conv_deg  in  DEG_W  converter result.
- i_conv_finished  in  1  converter completion pulse.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Grant pointer last = N_REQ-1, so requester 0 has top priority after reset.
  - Timer, owner and operand registers 0.
- Reset mid-operation aborts immediately. No o_done is issued for the in-flight request, and the converter must be reset by the same i_rst.
- States IDLE → LAUNCH → WAIT → DELIVER → IDLE. All outputs are registered.
- IDLE:
  - If i_req is nonzero, search from (last+1) mod N_REQ upward with wrap. The first set bit is the owner.
  - Capture the owner index and the owner's operand, then go to LAUNCH.
  - If i_req is zero, stay in IDLE.
- LAUNCH (exactly 1 cycle):
  - o_ack[owner]=1, o_conv_start=1, timer cleared.
  - Next state is WAIT.
- WAIT:
  - o_conv_binary holds the captured operand from LAUNCH through the end of WAIT; otherwise it is 0.
  - The timer increments every cycle.
  - If i_conv_finished=1: latch i_conv_deg into o_deg, set err=0, go to DELIVER.
  - Else if timer == TIMEOUT_CYC-1: set o_deg=0, err=1, go to DELIVER.
  - If finished arrives on the same cycle the timer expires, finished wins (err=0).
- DELIVER (exactly 1 cycle):
  - o_done[owner]=1, o_err=err, last=owner.
  - Next state is IDLE. o_deg returns to 0 the following cycle.
- i_conv_finished outside WAIT is ignored.
- Changes to i_req or i_binary after capture have no effect on the current conversion.
- Requester protocol:
  - Hold i_req and i_binary stable until o_ack.
  - Deassert i_req in the cycle after o_ack unless a new conversion is wanted.
  - A request still high in IDLE is re-arbitrated as new.
- At most one o_ack bit and one o_done bit are high at any time. o_ack and o_done are never high in the same cycle.
- Latency:
  - i_req seen in IDLE at cycle t gives o_ack and o_conv_start at t+1.
  - o_done is 1 cycle after finished is sampled.
  - Minimum turnaround is 3 + converter latency cycles. IDLE spends at least 1 cycle between grants, which gives the converter time to return to its idle state.

Test Plan:
- Single request: reset, then i_req=4'b0001 with operand 22'h2D0000; converter model returns finished after 16 cycles with deg 14'h00B4 → o_ack[0] one cycle after request, o_done[0] with o_deg=14'h00B4 and o_err=0, o_busy low afterwards.
- Round-robin: all four requests held high continuously → grants in order 0,1,2,3,0, each o_done carrying its own operand's result, no overlap of o_ack or o_done pulses.
- Pointer wrap: after serving requester 2, requests from 1 and 3 are raised together → 3 is granted first, then 1.
- Timeout: converter never raises finished → o_done[owner] exactly TIMEOUT_CYC cycles after LAUNCH, with o_err=1 and o_deg=0; the next request is then served normally.
- Finished coincides with timer expiry (finished at WAIT cycle TIMEOUT_CYC-1) → o_err=0 and o_deg equals the converter value.
- Reset during WAIT: i_rst pulsed → all outputs 0 in the same cycle (asynchronous); no o_done for the aborted request; the first grant after release goes to the lowest-index active requester.

Source files
------------

// File: rtl/deg_conv_arbiter.sv
// Round-robin arbiter sharing a single binary-to-degree converter between N_REQ requesters.
// One request is served at a time: capture operand, launch, wait for finished or timeout, deliver.
module deg_conv_arbiter #(
    parameter int N_REQ       = 4,
    parameter int BIN_W       = 22,
    parameter int DEG_W       = 14,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*BIN_W-1:0] i_binary,
    output logic [N_REQ-1:0]       o_ack,
    output logic [N_REQ-1:0]       o_done,
    output logic [DEG_W-1:0]       o_deg,
    output logic                   o_err,
    output logic                   o_busy,
    output logic                   o_conv_start,
    output logic [BIN_W-1:0]       o_conv_binary,
    input  logic [DEG_W-1:0]       i_conv_deg,
    input  logic                   i_conv_finished,
    output logic [1:0]             o_dbg_state
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [BIN_W-1:0]   operand_q, operand_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [DEG_W-1:0]   deg_q, deg_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    logic [BIN_W-1:0]   conv_bin_q, conv_bin_d;

    logic               arb_found;
    logic [IDX_W-1:0]   arb_idx;
    logic [BIN_W-1:0]   arb_op;

    // Search starts one past the last served requester, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_op    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_q) + i) % N_REQ;
            if (!arb_found && i_req[idx]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'(idx);
                arb_op    = i_binary[idx*BIN_W +: BIN_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        operand_d  = operand_q;
        timer_d    = timer_q;
        ack_d      = '0;
        done_d     = '0;
        deg_d      = '0;
        err_d      = 1'b0;
        start_d    = 1'b0;
        conv_bin_d = '0;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    owner_d        = arb_idx;
                    operand_d      = arb_op;
                    timer_d        = '0;
                    ack_d[arb_idx] = 1'b1;
                    start_d        = 1'b1;
                    conv_bin_d     = arb_op;
                    state_d        = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                timer_d    = timer_q + TMR_W'(1);
                conv_bin_d = operand_q;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // A finished pulse on the expiry cycle still counts as a good result.
                if (i_conv_finished) begin
                    deg_d           = i_conv_deg;
                    done_d[owner_q] = 1'b1;
                    state_d         = S_DELIVER;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    err_d           = 1'b1;
                    done_d[owner_q] = 1'b1;
                    state_d         = S_DELIVER;
                end else begin
                    conv_bin_d = operand_q;
                end
            end
            S_DELIVER: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            last_q     <= IDX_W'(N_REQ - 1);
            owner_q    <= '0;
            operand_q  <= '0;
            timer_q    <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            deg_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            conv_bin_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            operand_q  <= operand_d;
            timer_q    <= timer_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            deg_q      <= deg_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            conv_bin_q <= conv_bin_d;
        end
    end

    assign o_ack         = ack_q;
    assign o_done        = done_q;
    assign o_deg         = deg_q;
    assign o_err         = err_q;
    assign o_busy        = busy_q;
    assign o_conv_start  = start_q;
    assign o_conv_binary = conv_bin_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_deg_conv_arbiter.sv
// Directed bench for deg_conv_arbiter; the bench itself plays the converter.
module tb_deg_conv_arbiter;

    localparam int N_REQ = 4;
    localparam int BIN_W = 22;
    localparam int DEG_W = 14;
    localparam int TMO   = 64;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*BIN_W-1:0] bin;
    logic [N_REQ-1:0]       ack;
    logic [N_REQ-1:0]       done;
    logic [DEG_W-1:0]       deg;
    logic                   err;
    logic                   busy;
    logic                   conv_start;
    logic [BIN_W-1:0]       conv_binary;
    logic [DEG_W-1:0]       conv_deg;
    logic                   conv_finished;
    logic [1:0]             dbg_state;

    int errors = 0;
    int checks = 0;

    deg_conv_arbiter #(
        .N_REQ(N_REQ), .BIN_W(BIN_W), .DEG_W(DEG_W), .TIMEOUT_CYC(TMO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_binary(bin),
        .o_ack(ack), .o_done(done), .o_deg(deg), .o_err(err), .o_busy(busy),
        .o_conv_start(conv_start), .o_conv_binary(conv_binary),
        .i_conv_deg(conv_deg), .i_conv_finished(conv_finished),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    task automatic set_op(input int k, input logic [BIN_W-1:0] v);
        bin[k*BIN_W +: BIN_W] = v;
    endtask

    // Bounded wait for any ack pulse (at most 10 cycles).
    task automatic wait_ack();
        for (int n = 0; n < 10; n++) begin
            tick();
            if (ack != '0) break;
        end
    endtask

    // Expect a grant to `owner`, answer as the converter after `lat` cycles, check delivery.
    task automatic serve(input string tag, input int owner, input logic [BIN_W-1:0] op,
                         input logic [DEG_W-1:0] res, input int lat, input logic [N_REQ-1:0] drop);
        logic [N_REQ-1:0] onehot;
        onehot = N_REQ'(1) << owner;
        wait_ack();
        check({tag, "_ack"}, 64'(ack), 64'(onehot));
        check({tag, "_start"}, 64'(conv_start), 64'd1);
        check({tag, "_bin"}, 64'(conv_binary), 64'(op));
        check({tag, "_ack_done_overlap"}, 64'(done), 64'd0);
        req = req & ~drop;
        repeat (lat) tick();
        conv_finished = 1'b1;
        conv_deg      = res;
        tick();
        conv_finished = 1'b0;
        conv_deg      = '0;
        check({tag, "_done"}, 64'(done), 64'(onehot));
        check({tag, "_deg"}, 64'(deg), 64'(res));
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_done_ack_overlap"}, 64'(ack), 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        req           = '0;
        bin           = '0;
        conv_deg      = '0;
        conv_finished = 1'b0;
        tick();
        tick();
        check("reset_outputs", {ack, done, deg, err, busy, conv_start, conv_binary}, 64'd0);
        rst = 1'b0;
        tick();

        // Single request from requester 0, converter answers 16 cycles after start.
        set_op(0, 22'h2D0000);
        req = 4'b0001;
        tick();
        check("single_ack_latency", 64'(ack), 64'h1);
        check("single_busy", 64'(busy), 64'd1);
        req = 4'b0000;
        tick();
        check("single_ack_pulse", 64'(ack), 64'd0);
        check("single_bin_held", 64'(conv_binary), 64'h2D0000);
        repeat (14) tick();
        conv_finished = 1'b1;
        conv_deg      = 14'h00B4;
        tick();
        conv_finished = 1'b0;
        conv_deg      = '0;
        check("single_done", 64'(done), 64'h1);
        check("single_deg", 64'(deg), 64'h00B4);
        check("single_err", 64'(err), 64'd0);
        tick();
        check("single_busy_after", 64'(busy), 64'd0);
        check("single_deg_cleared", 64'(deg), 64'd0);

        // Finished outside WAIT must be ignored.
        conv_finished = 1'b1;
        conv_deg      = 14'h1234;
        tick();
        conv_finished = 1'b0;
        conv_deg      = '0;
        tick();
        check("idle_finished_ignored", {done, busy, deg}, 64'd0);

        // Round robin with all requests held; fresh reset puts requester 0 first.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_op(0, 22'h2D0000);
        set_op(1, 22'h012345);
        set_op(2, 22'h3ABCDE);
        set_op(3, 22'h0F0F0F);
        req = 4'b1111;
        serve("rr0", 0, 22'h2D0000, 14'h00B4, 3, 4'b0000);
        serve("rr1", 1, 22'h012345, 14'h0111, 3, 4'b0000);
        serve("rr2", 2, 22'h3ABCDE, 14'h0222, 5, 4'b0000);
        serve("rr3", 3, 22'h0F0F0F, 14'h0333, 2, 4'b0000);
        serve("rr0b", 0, 22'h2D0000, 14'h00B5, 1, 4'b1111);
        tick();
        check("rr_idle", 64'(busy), 64'd0);

        // Pointer wrap: after requester 2, requesters 1 and 3 together give 3 then 1.
        req = 4'b0100;
        serve("wrap2", 2, 22'h3ABCDE, 14'h0022, 2, 4'b0100);
        req = 4'b1010;
        serve("wrap3", 3, 22'h0F0F0F, 14'h0033, 2, 4'b1000);
        serve("wrap1", 1, 22'h012345, 14'h0011, 2, 4'b0010);

        // Timeout: converter never answers.
        set_op(0, 22'h001000);
        req = 4'b0001;
        wait_ack();
        check("tmo_ack", 64'(ack), 64'h1);
        req = 4'b0000;
        repeat (TMO - 1) tick();
        check("tmo_not_early", 64'(done), 64'd0);
        check("tmo_bin_held", 64'(conv_binary), 64'h001000);
        tick();
        check("tmo_done", 64'(done), 64'h1);
        check("tmo_err", 64'(err), 64'd1);
        check("tmo_deg", 64'(deg), 64'd0);
        check("tmo_bin_cleared", 64'(conv_binary), 64'd0);
        tick();
        check("tmo_err_pulse", {err, busy}, 64'd0);
        req = 4'b0010;
        serve("after_tmo", 1, 22'h012345, 14'h0A5A, 4, 4'b0010);

        // Finished on the very cycle the timer expires: result wins.
        req = 4'b0100;
        wait_ack();
        check("coin_ack", 64'(ack), 64'h4);
        req = 4'b0000;
        repeat (TMO - 1) tick();
        check("coin_not_early", 64'(done), 64'd0);
        conv_finished = 1'b1;
        conv_deg      = 14'h3FFF;
        tick();
        conv_finished = 1'b0;
        conv_deg      = '0;
        check("coin_done", 64'(done), 64'h4);
        check("coin_err", 64'(err), 64'd0);
        check("coin_deg", 64'(deg), 64'h3FFF);

        // Reset during WAIT aborts without a done; pointer restarts at requester 0.
        req = 4'b1000;
        wait_ack();
        check("rst_ack", 64'(ack), 64'h8);
        req = 4'b0000;
        repeat (5) tick();
        check("rst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #2;
        check("rst_async_outputs", {ack, done, deg, err, busy, conv_start, conv_binary}, 64'd0);
        tick();
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            check("rst_no_done", 64'(done), 64'd0);
        end
        req = 4'b0110;
        serve("post_rst1", 1, 22'h012345, 14'h0101, 3, 4'b0010);
        serve("post_rst2", 2, 22'h3ABCDE, 14'h0202, 3, 4'b0100);
        tick();
        check("final_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
